regfile_scoreboard: RTL

Parametrised integer register file with NRD combinational read ports and one synchronous write port. It replaces the fixed 2-read/32-entry register file in the pipelined core. A per-register pending-write counter forms the scoreboard: decode issues destinations, writeback retires them, and a RAW hazard flag tells decode when to stall. Register 0 is hard-wired to zero, and the stack-pointer register comes out of reset at a configurable value.

---
 rtl/regfile_scoreboard.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with NRD combinational read
// ports, one synchronous write port and a per-register pending-write counter
// scoreboard that flags RAW hazards for decode.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// forwarding on the read ports and on the hazard check.
module regfile_scoreboard #(
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned CNTW     = 2,
   parameter int unsigned SP_IDX   = 2,
   parameter logic [31:0] SP_RESET = 32'hFFFFFFFC,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     rs_addr_i,
   input  logic [NRD-1:0]        rs_valid_i,
   output logic [NRD*DWIDTH-1:0] rs_data_o,
   input  logic                  issue_i,
   input  logic [AW-1:0]         issue_rd_i,
   output logic                  issue_ready_o,
   input  logic                  wb_en_i,
   input  logic [AW-1:0]         wb_rd_i,
   input  logic [DWIDTH-1:0]     wb_data_i,
   output logic                  hazard_o
);

   localparam logic [DWIDTH-1:0] SP_RST_VAL = DWIDTH'(SP_RESET);
   localparam logic [CNTW-1:0]   CNT_MAX    = '1;

   logic [DWIDTH-1:0] regs_q [NREGS];
   logic [DWIDTH-1:0] regs_d [NREGS];
   logic [CNTW-1:0]   cnt_q  [NREGS];
   logic [CNTW-1:0]   cnt_d  [NREGS];

   logic              issue_acc;
   logic              wb_act;
   logic              retire_same;
   logic [NREGS-1:0]  inc_v;
   logic [NREGS-1:0]  dec_v;
   logic [AW-1:0]     rd_addr [NRD];
`ifdef REGFILE_BYPASS_EN
   logic [NRD-1:0]    fwd_clear;
`endif

   // Issue handshake: full counter blocks unless the same register retires now
   always_comb begin
      retire_same   = wb_en_i && (wb_rd_i == issue_rd_i);
      issue_ready_o = 1'b1;
      if ((issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX) && !retire_same) begin
         issue_ready_o = 1'b0;
      end
      issue_acc = issue_i && issue_ready_o && (issue_rd_i != '0);
      wb_act    = wb_en_i && (wb_rd_i != '0);
   end

   // Next-state for register contents and pending counters
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int r = 0; r < NREGS; r++) begin
         regs_d[r] = regs_q[r];
         cnt_d[r]  = cnt_q[r];
         inc_v[r]  = issue_acc && (issue_rd_i == AW'(r));
         dec_v[r]  = wb_act && (wb_rd_i == AW'(r));
         if (dec_v[r]) begin
            regs_d[r] = wb_data_i;
         end
         if (inc_v[r] && !dec_v[r]) begin
            cnt_d[r] = cnt_q[r] + CNTW'(1);
         end else if (dec_v[r] && !inc_v[r] && (cnt_q[r] != '0)) begin
            // a retire with nothing pending leaves the counter at zero
            cnt_d[r] = cnt_q[r] - CNTW'(1);
         end
      end
      regs_d[0] = '0;
      cnt_d[0]  = '0;
   end

   // State registers with synchronous reset; SP comes up at its reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= (r == int'(SP_IDX)) ? SP_RST_VAL : '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
      end
   end

   // Read ports and RAW hazard detection
   always_comb begin
      rs_data_o = '0;
      hazard_o  = 1'b0;
`ifdef REGFILE_BYPASS_EN
      fwd_clear = '0;
`endif
      for (int k = 0; k < NRD; k++) begin
         rd_addr[k] = rs_addr_i[k*AW +: AW];
         if (rd_addr[k] != '0) begin
            rs_data_o[k*DWIDTH +: DWIDTH] = regs_q[rd_addr[k]];
         end
`ifdef REGFILE_BYPASS_EN
         // forward the writeback and drop the stall when it retires the last pending write
         if (wb_act && (wb_rd_i == rd_addr[k])) begin
            rs_data_o[k*DWIDTH +: DWIDTH] = wb_data_i;
            fwd_clear[k] = (cnt_q[rd_addr[k]] == CNTW'(1)) &&
                           !(issue_acc && (issue_rd_i == rd_addr[k]));
         end
         if (rs_valid_i[k] && (rd_addr[k] != '0) && (cnt_q[rd_addr[k]] != '0) && !fwd_clear[k]) begin
            hazard_o = 1'b1;
         end
`else
         if (rs_valid_i[k] && (rd_addr[k] != '0) && (cnt_q[rd_addr[k]] != '0)) begin
            hazard_o = 1'b1;
         end
`endif
      end
   end

endmodule
